// File: rtl/iir_bw3_pkg.sv
// Shared widths and Q2.14 coefficients for the 3rd-order Butterworth low-pass (fc = fs/10).
package iir_bw3_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned FRAC_W = 14;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned PROD_W = DATA_W + COEF_W;

    localparam logic signed [COEF_W-1:0] B0 = 16'sd297;
    localparam logic signed [COEF_W-1:0] B1 = 16'sd890;
    localparam logic signed [COEF_W-1:0] B2 = 16'sd890;
    localparam logic signed [COEF_W-1:0] B3 = 16'sd297;
    localparam logic signed [COEF_W-1:0] A1 = -16'sd28837;
    localparam logic signed [COEF_W-1:0] A2 = 16'sd19381;
    localparam logic signed [COEF_W-1:0] A3 = -16'sd4556;

endpackage

// File: rtl/iir_round_sat.sv
// Rounds the Q4.28 accumulator back to Q2.14 (half up) and clamps or wraps to DATA_W.
// Build option: IIR_SATURATE_EN selects clamping; otherwise the result wraps.
module iir_round_sat
    import iir_bw3_pkg::*;
(
    input  logic [ACC_W-1:0]  acc_i,
    output logic [DATA_W-1:0] y_c_o
);

    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(64'sd8192);
    localparam logic signed [ACC_W-1:0] MAX_V    = ACC_W'(64'sd32767);
    localparam logic signed [ACC_W-1:0] MIN_V    = ACC_W'(-64'sd32768);

    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] shifted_c;
    logic                    unused_bits_c;

    assign sum_c         = $signed(acc_i) + HALF_LSB;
    assign shifted_c     = sum_c >>> FRAC_W;
    assign unused_bits_c = ^{sum_c, shifted_c};

`ifdef IIR_SATURATE_EN
    always_comb begin
        y_c_o = shifted_c[DATA_W-1:0];
        if (shifted_c > MAX_V) begin
            y_c_o = MAX_V[DATA_W-1:0];
        end else if (shifted_c < MIN_V) begin
            y_c_o = MIN_V[DATA_W-1:0];
        end
    end
`else
    assign y_c_o = shifted_c[DATA_W-1:0];
`endif

endmodule

// File: rtl/iir_butterworth_order3.sv
// 3rd-order Butterworth low-pass, direct form I, one Q2.14 sample per clock, registered output.
// Build option: IIR_SATURATE_EN (clamp instead of wrap, handled in iir_round_sat).
module iir_butterworth_order3
    import iir_bw3_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] x_n,
    output logic [DATA_W-1:0] y_n
);

    logic [DATA_W-1:0] x1_q, x2_q, x3_q;
    logic [DATA_W-1:0] y1_q, y2_q, y3_q;
    logic [DATA_W-1:0] y_q;
    logic [DATA_W-1:0] x1_d, x2_d, x3_d;
    logic [DATA_W-1:0] y1_d, y2_d, y3_d;
    logic [DATA_W-1:0] y_d;

    logic signed [PROD_W-1:0] pb0_c, pb1_c, pb2_c, pb3_c;
    logic signed [PROD_W-1:0] pa1_c, pa2_c, pa3_c;
    logic signed [ACC_W-1:0]  acc_c;
    logic [DATA_W-1:0]        y_c;

    // Seven-term MAC over the current input and both delay lines
    always_comb begin
        pb0_c = B0 * $signed(x_n);
        pb1_c = B1 * $signed(x1_q);
        pb2_c = B2 * $signed(x2_q);
        pb3_c = B3 * $signed(x3_q);
        pa1_c = A1 * $signed(y1_q);
        pa2_c = A2 * $signed(y2_q);
        pa3_c = A3 * $signed(y3_q);
        acc_c = ACC_W'(pb0_c) + ACC_W'(pb1_c) + ACC_W'(pb2_c) + ACC_W'(pb3_c)
              - ACC_W'(pa1_c) - ACC_W'(pa2_c) - ACC_W'(pa3_c);
    end

    iir_round_sat u_round_sat (
        .acc_i (acc_c),
        .y_c_o (y_c)
    );

    // Feedback taps take the same post-saturation value that drives y_n
    always_comb begin
        y_d  = y_c;
        x1_d = x_n;
        x2_d = x1_q;
        x3_d = x2_q;
        y1_d = y_c;
        y2_d = y1_q;
        y3_d = y2_q;
    end

    // rst_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            y_q  <= '0;
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
            y3_q <= '0;
        end else begin
            y_q  <= y_d;
            x1_q <= x1_d;
            x2_q <= x2_d;
            x3_q <= x3_d;
            y1_q <= y1_d;
            y2_q <= y2_d;
            y3_q <= y3_d;
        end
    end

    assign y_n = y_q;

endmodule

// File: tb/tb_iir_butterworth_order3.sv
// Self-checking bench: difference-equation reference model versus the filter, directed and random stimulus.
module tb_iir_butterworth_order3;

    logic        clk;
    logic        rst_n;
    logic [15:0] x_n;
    logic [15:0] y_n;

    int n_cmp;
    int n_err;

    longint xh[4];
    longint yh[4];
    int     sine_lut[32];

    iir_butterworth_order3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x_n   (x_n),
        .y_n   (y_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // y[n] = sum(b*x) - sum(a*y), round half up, clamp or wrap to 16 bits
    function automatic int model_step(input int x, input bit rst);
        longint acc;
        longint ys;
        logic [15:0] t;
        int y;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                xh[i] = 0;
                yh[i] = 0;
            end
            return 0;
        end
        xh[0] = x;
        acc = 297 * xh[0] + 890 * xh[1] + 890 * xh[2] + 297 * xh[3]
            - (-28837) * yh[1] - 19381 * yh[2] - (-4556) * yh[3];
        ys = (acc + 8192) >>> 14;
`ifdef IIR_SATURATE_EN
        if (ys > 32767) ys = 32767;
        if (ys < -32768) ys = -32768;
`endif
        t = ys[15:0];
        y = int'($signed(t));
        xh[3] = xh[2]; xh[2] = xh[1]; xh[1] = xh[0];
        yh[3] = yh[2]; yh[2] = yh[1]; yh[1] = longint'(y);
        return y;
    endfunction

    // One sample: drive on the falling edge, sample #1 after the rising edge, compare to the model
    task automatic step(input int x, input bit rst, input string tag, output int got);
        int exp;
        logic [15:0] xv;
        @(negedge clk);
        xv    = x[15:0];
        x_n   = xv;
        rst_n = rst;
        @(posedge clk);
        #1;
        exp = model_step(int'($signed(xv)), rst);
        got = int'($signed(y_n));
        check_val(tag, got, exp);
    endtask

    initial begin
        int got;
        int ymax;
        int ymin;
        int first;
        bit seen_neg;
        n_cmp = 0;
        n_err = 0;
        x_n   = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xh[i] = 0;
            yh[i] = 0;
        end
        for (int i = 0; i < 32; i++)
            sine_lut[i] = int'($rtoi(16383.0 * $sin(2.0 * 3.14159265358979 * i / 32.0) + ((i < 16) ? 0.5 : -0.5)));

        // Reset held with a nonzero input: output stays zero
        for (int i = 0; i < 5; i++) begin
            step(1000, 1'b1, "reset", got);
            check_val("reset_zero", got, 0);
        end

        // Impulse
        step(8192, 1'b0, "impulse", first);
        check_val("impulse_first", first, 149);
        for (int i = 0; i < 60; i++) step(0, 1'b0, "impulse", got);
        check_val("impulse_settled", (got <= 2 && got >= -2) ? 1 : 0, 1);

        // DC step from a fresh start
        step(0, 1'b1, "step_rst", got);
        ymax = -40000;
        for (int i = 0; i < 50; i++) begin
            step(8192, 1'b0, "dc_step", got);
            if (got > ymax) ymax = got;
        end
        check_val("dc_overshoot", (ymax < 9000 && ymax > 8192) ? 1 : 0, 1);

        // Sine at fs/32, peak over the last two periods
        step(0, 1'b1, "sine_rst", got);
        ymax = -40000;
        for (int i = 0; i < 16 * 32; i++) begin
            step(sine_lut[i % 32], 1'b0, "sine", got);
            if (i >= 14 * 32 && got > ymax) ymax = got;
        end
        check_val("sine_peak", (ymax >= 15892 && ymax <= 16874) ? 1 : 0, 1);

        // Reset for one cycle at the sine peak, then restart
        for (int i = 0; i < 8; i++) step(sine_lut[i], 1'b0, "sine_pre", got);
        step(sine_lut[8], 1'b1, "mid_rst", got);
        check_val("mid_rst_zero", got, 0);
        for (int i = 0; i < 64; i++) step(sine_lut[i % 32], 1'b0, "sine_restart", got);

        // Nyquist alternation is rejected
        step(0, 1'b1, "nyq_rst", got);
        ymax = 0;
        for (int i = 0; i < 60; i++) begin
            step((i % 2 == 0) ? 16383 : -16383, 1'b0, "nyquist", got);
            if (i >= 30 && (got > ymax || -got > ymax)) ymax = (got < 0) ? -got : got;
        end
        check_val("nyquist_small", (ymax < 64) ? 1 : 0, 1);

        // Full-scale step: clamps or wraps on overshoot
        step(0, 1'b1, "sat_rst", got);
        ymax = -40000;
        ymin = 40000;
        seen_neg = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(32767, 1'b0, "fullscale", got);
            if (got > ymax) ymax = got;
            if (got < ymin) ymin = got;
            if (got < 0) seen_neg = 1'b1;
        end
`ifdef IIR_SATURATE_EN
        check_val("sat_clamp_max", ymax, 32767);
        check_val("sat_never_neg", (ymin >= 0) ? 1 : 0, 1);
`else
        check_val("wrap_seen_neg", int'(seen_neg), 1);
`endif

        // Random samples with occasional resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(16000) - 8000, ($urandom_range(49) == 0), "random", got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
